// File: rtl/id_stage.sv
// Instruction-decode stage of the 5-stage MIPS pipeline: register file, main decoder,
// load-use hazard detection, beq resolution and the ID/EX pipeline register.
module id_stage #(
  parameter int RF_DEPTH = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     if_id_ir,
  input  logic [XLEN-1:0] if_id_npc,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_write_reg,
  input  logic [XLEN-1:0] wb_write_data,
  output logic            pcsrc,
  output logic [XLEN-1:0] branch_target,
  output logic            stall,
  output logic            if_id_flush,
  output logic [XLEN-1:0] id_ex_npc,
  output logic [XLEN-1:0] id_ex_rdata1,
  output logic [XLEN-1:0] id_ex_rdata2,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rs,
  output logic [4:0]      id_ex_rt,
  output logic [4:0]      id_ex_rd,
  output logic            id_ex_regwrite,
  output logic            id_ex_memtoreg,
  output logic            id_ex_memread,
  output logic            id_ex_memwrite,
  output logic            id_ex_regdst,
  output logic            id_ex_alusrc,
  output logic [1:0]      id_ex_aluop
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
  } ctrl_t;

  logic [5:0]      opcode;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic [XLEN-1:0] rf [RF_DEPTH];
  ctrl_t           ctrl;
  logic            uses_rt;

  assign opcode = if_id_ir[31:26];
  assign rs     = if_id_ir[25:21];
  assign rt     = if_id_ir[20:16];
  assign rd     = if_id_ir[15:11];
  assign imm    = {{(XLEN-16){if_id_ir[15]}}, if_id_ir[15:0]};

  // NOTE: the register file is cleared on reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else if (wb_regwrite && wb_write_reg != 5'd0) begin
      rf[wb_write_reg] <= wb_write_data;
    end
  end

  // Writeback data bypasses the array so a same-cycle write is seen by this decode.
  assign rdata1 = (rs == 5'd0) ? '0 :
                  (wb_regwrite && wb_write_reg == rs) ? wb_write_data : rf[rs];
  assign rdata2 = (rt == 5'd0) ? '0 :
                  (wb_regwrite && wb_write_reg == rt) ? wb_write_data : rf[rt];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ctrl    = '0;
    uses_rt = 1'b0;
    unique case (opcode)
      OP_R:    begin ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10}; uses_rt = 1'b1; end
      OP_LW:   ctrl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
      OP_SW:   begin ctrl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00}; uses_rt = 1'b1; end
      OP_BEQ:  begin ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01}; uses_rt = 1'b1; end
      OP_ADDI: ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
      default: ctrl = '0;
    endcase
  end

  // A load in EX whose target feeds this instruction forces one bubble.
  assign stall = id_ex_memread && (id_ex_rt != 5'd0) &&
                 ((id_ex_rt == rs) || ((id_ex_rt == rt) && uses_rt));

  assign pcsrc         = (opcode == OP_BEQ) && (rdata1 == rdata2) && !stall;
  assign if_id_flush   = pcsrc;
  assign branch_target = if_id_npc + {imm[XLEN-3:0], 2'b00};

  // NOTE: pipeline state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || stall) begin
      if (!reset || stall) begin
        id_ex_npc      <= '0;
        id_ex_rdata1   <= '0;
        id_ex_rdata2   <= '0;
        id_ex_imm      <= '0;
        id_ex_rs       <= '0;
        id_ex_rt       <= '0;
        id_ex_rd       <= '0;
        id_ex_regwrite <= 1'b0;
        id_ex_memtoreg <= 1'b0;
        id_ex_memread  <= 1'b0;
        id_ex_memwrite <= 1'b0;
        id_ex_regdst   <= 1'b0;
        id_ex_alusrc   <= 1'b0;
        id_ex_aluop    <= 2'b00;
      end
    end else begin
      id_ex_npc      <= if_id_npc;
      id_ex_rdata1   <= rdata1;
      id_ex_rdata2   <= rdata2;
      id_ex_imm      <= imm;
      id_ex_rs       <= rs;
      id_ex_rt       <= rt;
      id_ex_rd       <= rd;
      id_ex_regwrite <= ctrl.regwrite;
      id_ex_memtoreg <= ctrl.memtoreg;
      id_ex_memread  <= ctrl.memread;
      id_ex_memwrite <= ctrl.memwrite;
      id_ex_regdst   <= ctrl.regdst;
      id_ex_alusrc   <= ctrl.alusrc;
      id_ex_aluop    <= ctrl.aluop;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a reference model predicts each ID/EX load into a
// scoreboard queue; a monitor pops and compares one entry per rising edge.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_id_ir, if_id_npc;
  logic        wb_regwrite;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        pcsrc, stall, if_id_flush;
  logic [31:0] branch_target;
  logic [31:0] id_ex_npc, id_ex_rdata1, id_ex_rdata2, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic        id_ex_regwrite, id_ex_memtoreg, id_ex_memread, id_ex_memwrite;
  logic        id_ex_regdst, id_ex_alusrc;
  logic [1:0]  id_ex_aluop;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
  } idex_t;

  idex_t       q[$];
  idex_t       got;
  idex_t       popped;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_rf [32];
  logic        m_ex_memread;
  logic [4:0]  m_ex_rt;
  logic        m_stall, m_pcsrc;

  id_stage dut (
    .clk(clk), .reset(reset), .if_id_ir(if_id_ir), .if_id_npc(if_id_npc),
    .wb_regwrite(wb_regwrite), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .pcsrc(pcsrc), .branch_target(branch_target), .stall(stall), .if_id_flush(if_id_flush),
    .id_ex_npc(id_ex_npc), .id_ex_rdata1(id_ex_rdata1), .id_ex_rdata2(id_ex_rdata2),
    .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_memtoreg(id_ex_memtoreg),
    .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite),
    .id_ex_regdst(id_ex_regdst), .id_ex_alusrc(id_ex_alusrc), .id_ex_aluop(id_ex_aluop)
  );

  always #5 clk = ~clk;

  assign got = {id_ex_npc, id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_rs, id_ex_rt, id_ex_rd,
                id_ex_regwrite, id_ex_memtoreg, id_ex_memread, id_ex_memwrite,
                id_ex_regdst, id_ex_alusrc, id_ex_aluop};

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      popped = q.pop_front();
      total++;
      if (got !== popped) begin
        bad++;
        $display("FAIL id_ex t=%0t got=%h exp=%h", $time, got, popped);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mread(input logic [4:0] src, input logic wr,
                                        input logic [4:0] wreg, input logic [31:0] wdata);
    if (src == 5'd0) return 32'h0;
    if (wr && wreg == src) return wdata;
    return m_rf[src];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_ex_memread = 1'b0;
    m_ex_rt      = 5'd0;
  endtask

  // Drives one decode cycle and pushes the ID/EX value the model predicts for the next edge.
  task automatic apply(input logic [31:0] ir, input logic [31:0] npc, input logic wr,
                       input logic [4:0] wreg, input logic [31:0] wdata);
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] a, b;
    idex_t       e;
    if_id_ir = ir; if_id_npc = npc;
    wb_regwrite = wr; wb_write_reg = wreg; wb_write_data = wdata;
    op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16];
    a = mread(rs, wr, wreg, wdata);
    b = mread(rt, wr, wreg, wdata);
    m_stall = m_ex_memread && (m_ex_rt != 5'd0) &&
              ((m_ex_rt == rs) || ((m_ex_rt == rt) && (op inside {6'h00, 6'h2B, 6'h04})));
    m_pcsrc = (op == 6'h04) && (a == b) && !m_stall;
    e = '0;
    if (!m_stall) begin
      e.npc = npc; e.rd1 = a; e.rd2 = b; e.imm = {{16{ir[15]}}, ir[15:0]};
      e.rs = rs; e.rt = rt; e.rd = ir[15:11];
      case (op)
        6'h00:   {e.regwrite, e.memtoreg, e.memread, e.memwrite, e.regdst, e.alusrc, e.aluop} = 8'b10001010;
        6'h23:   {e.regwrite, e.memtoreg, e.memread, e.memwrite, e.regdst, e.alusrc, e.aluop} = 8'b11100100;
        6'h2B:   {e.regwrite, e.memtoreg, e.memread, e.memwrite, e.regdst, e.alusrc, e.aluop} = 8'b00010100;
        6'h04:   {e.regwrite, e.memtoreg, e.memread, e.memwrite, e.regdst, e.alusrc, e.aluop} = 8'b00000001;
        6'h08:   {e.regwrite, e.memtoreg, e.memread, e.memwrite, e.regdst, e.alusrc, e.aluop} = 8'b10000100;
        default: {e.regwrite, e.memtoreg, e.memread, e.memwrite, e.regdst, e.alusrc, e.aluop} = 8'b00000000;
      endcase
    end
    q.push_back(e);
    if (wr && wreg != 5'd0) m_rf[wreg] = wdata;
    m_ex_memread = e.memread;
    m_ex_rt      = e.rt;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] npc, input logic wr,
                       input logic [4:0] wreg, input logic [31:0] wdata);
    @(negedge clk);
    apply(ir, npc, wr, wreg, wdata);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    if_id_ir = 32'h8C220004; if_id_npc = 32'h4;
    wb_regwrite = 1'b0; wb_write_reg = 5'd0; wb_write_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (got !== idex_t'(0)) begin bad++; $display("FAIL reset_idex got=%h exp=0", got); end
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    @(negedge clk);
    reset = 1'b1;
    apply(32'h8C220004, 32'h4, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_bypass();
    drive(32'h00A63020, 32'h8, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL bypass_stall got=%b exp=0", stall); end
    drive(32'h00A00020, 32'hC, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_r0();
    drive(32'h00001020, 32'h10, 1'b1, 5'd0, 32'h1234);
    drive(32'h00001020, 32'h14, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_load_use();
    drive(32'h8C220004, 32'h20, 1'b0, 5'd0, 32'h0);
    drive(32'h00441820, 32'h24, 1'b0, 5'd0, 32'h0);
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL lu_rs_stall got=%b exp=1", stall); end
    drive(32'h00441820, 32'h24, 1'b0, 5'd0, 32'h0);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", stall); end
    drive(32'h8C220004, 32'h28, 1'b0, 5'd0, 32'h0);
    drive(32'hAC620000, 32'h2C, 1'b0, 5'd0, 32'h0);
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL lu_sw_rt got=%b exp=1", stall); end
    drive(32'hAC620000, 32'h2C, 1'b0, 5'd0, 32'h0);
    drive(32'h8C220004, 32'h30, 1'b0, 5'd0, 32'h0);
    drive(32'h20620001, 32'h34, 1'b0, 5'd0, 32'h0);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL lu_addi_rt got=%b exp=0", stall); end
  endtask

  task automatic test_branch();
    drive(32'h00000000, 32'h80, 1'b1, 5'd1, 32'h7);
    drive(32'h00000000, 32'h84, 1'b1, 5'd2, 32'h7);
    drive(32'h10220003, 32'h100, 1'b0, 5'd0, 32'h0);
    #1;
    total++;
    if ({pcsrc, if_id_flush} !== 2'b11) begin bad++; $display("FAIL br_taken got=%b exp=11", {pcsrc, if_id_flush}); end
    total++;
    if (branch_target !== 32'h10C) begin bad++; $display("FAIL br_target got=%h exp=0000010c", branch_target); end
    drive(32'h10220003, 32'h100, 1'b1, 5'd2, 32'h8);
    #1;
    total++;
    if ({pcsrc, if_id_flush} !== 2'b00) begin bad++; $display("FAIL br_not_taken got=%b exp=00", {pcsrc, if_id_flush}); end
    drive(32'h1022FFFF, 32'h100, 1'b0, 5'd0, 32'h0);
    #1;
    total++;
    if (branch_target !== 32'hFC) begin bad++; $display("FAIL br_neg_target got=%h exp=000000fc", branch_target); end
    drive(32'h10220001, 32'hFFFFFFFC, 1'b0, 5'd0, 32'h0);
    #1;
    total++;
    if (branch_target !== 32'h0) begin bad++; $display("FAIL br_wrap got=%h exp=00000000", branch_target); end
    drive(32'h10000005, 32'h40, 1'b0, 5'd0, 32'h0);
    #1;
    total++;
    if ({pcsrc, branch_target} !== {1'b1, 32'h54}) begin
      bad++; $display("FAIL br_r0 got=%b/%h exp=1/00000054", pcsrc, branch_target);
    end
  endtask

  task automatic test_stall_beq();
    drive(32'h8C610000, 32'h60, 1'b1, 5'd2, 32'h7);
    drive(32'h10220003, 32'h100, 1'b0, 5'd0, 32'h0);
    #1;
    total++;
    if ({stall, pcsrc, if_id_flush} !== 3'b100) begin
      bad++; $display("FAIL sb_stall got=%b exp=100", {stall, pcsrc, if_id_flush});
    end
    drive(32'h10220003, 32'h100, 1'b0, 5'd0, 32'h0);
    #1;
    total++;
    if ({stall, pcsrc, if_id_flush} !== 3'b011) begin
      bad++; $display("FAIL sb_resolve got=%b exp=011", {stall, pcsrc, if_id_flush});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
    logic [31:0] r, npc, wd;
    logic [4:0]  wr_reg;
    logic        wr;
    for (int i = 0; i < 24; i++) begin
      r = $urandom;
      npc = $urandom & 32'hFFFF_FFFC;
      wd = $urandom;
      wr_reg = 5'($urandom_range(0, 7));
      wr = 1'($urandom_range(0, 1));
      r[31:26] = ops[$urandom_range(0, 5)];
      r[25:21] = 5'($urandom_range(0, 7));
      r[20:16] = 5'($urandom_range(0, 7));
      drive(r, npc, wr, wr_reg, wd);
      #1;
      total++;
      if ({stall, pcsrc, if_id_flush} !== {m_stall, m_pcsrc, m_pcsrc}) begin
        bad++; $display("FAIL b2b_hazard i=%0d got=%b exp=%b", i, {stall, pcsrc, if_id_flush}, {m_stall, m_pcsrc, m_pcsrc});
      end
      total++;
      if (branch_target !== npc + {{14{r[15]}}, r[15:0], 2'b00}) begin
        bad++; $display("FAIL b2b_target i=%0d got=%h exp=%h", i, branch_target, npc + {{14{r[15]}}, r[15:0], 2'b00});
      end
    end
  endtask

  task automatic test_async_reset();
    drive(32'h8C220004, 32'h200, 1'b1, 5'd5, 32'hCAFEF00D);
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    total++;
    if ({id_ex_memread, id_ex_regwrite, id_ex_npc} !== 34'h0) begin
      bad++; $display("FAIL async_reset got=%b/%b/%h exp=0/0/0", id_ex_memread, id_ex_regwrite, id_ex_npc);
    end
    @(negedge clk);
    reset = 1'b1;
    apply(32'h00A63020, 32'h300, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL drain got=%0d exp=0 pending", q.size()); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_r0();
    test_load_use();
    test_branch();
    test_stall_beq();
    test_back_to_back();
    drain();
    test_async_reset();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
